// File: rtl/bit_pkg.sv
// Shared definitions for the bit deserialiser.
//   state_t   : framing FSM states (S_IDLE / S_DATA / S_PAR)
//   DEF_WIDTH : default data bits per word
//   DEF_DEPTH : default output FIFO depth (power of 2, >= 2)
package bit_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // no bits held
    S_DATA = 2'd1,   // 1..WIDTH-1 bits held
    S_PAR  = 2'd2    // full data word held, waiting for parity bit
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO for deserialised words.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write request and data (ignored when full unless popping)
//   pop      : read request (ignored when empty)
//   dout     : head entry, driven straight from the storage registers
//   full, empty, count : occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// the low bits index storage, so they wrap modulo DEPTH.
module sync_fifo
  import bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wptr == rptr);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same
  // cycle; the write then lands in the slot being vacated.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bit_deser.sv
// Serial-to-parallel word deserialiser with output FIFO.
// Bits arrive LSB first on bit_in when bit_vld=1; each completed word is
// pushed into a DEPTH-entry FIFO presented on word_out/word_vld and popped
// on word_vld && word_rdy.
//   clk, rst   : clock, synchronous active-high reset (highest priority)
//   bit_in     : serial data bit
//   bit_vld    : bit_in valid this cycle
//   sync       : drop partial word and restart alignment (same-cycle bit
//                becomes bit 0 of the new word)
//   word_out   : FIFO head word
//   word_vld   : FIFO not empty
//   word_rdy   : consumer accepts head word
//   count      : FIFO occupancy
//   ovf        : sticky, set when a completed word is dropped on a full FIFO
//   par_err    : one-cycle pulse after a failing even-parity bit
// Build option: define BIT_DESER_PARITY_EN to expect an even-parity bit after
// each data word; otherwise par_err is constant 0.
module bit_deser
  import bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_vld,
  input  logic                     sync,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_vld,
  input  logic                     word_rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     par_err
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] merged;
  logic             last;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             full;
  logic             empty;

  // Held bits with the current bit dropped into its LSB-first position.
  always_comb begin
    merged      = sh;
    merged[cnt] = bit_in;
  end

  assign last = (cnt == CW'(WIDTH - 1));

`ifdef BIT_DESER_PARITY_EN
  logic perr_nx;
`endif

  always_comb begin
    state_nx  = state;
    sh_nx     = sh;
    cnt_nx    = cnt;
    push      = 1'b0;
    push_data = merged;
`ifdef BIT_DESER_PARITY_EN
    perr_nx   = 1'b0;
`endif
    if (sync) begin
      // Restart overrides any word completion in the same cycle.
      state_nx = S_IDLE;
      sh_nx    = '0;
      cnt_nx   = '0;
      if (bit_vld) begin
        state_nx = S_DATA;
        sh_nx    = {{(WIDTH-1){1'b0}}, bit_in};
        cnt_nx   = CW'(1);
      end
    end else if (bit_vld) begin
      case (state)
        S_IDLE: begin
          state_nx = S_DATA;
          sh_nx    = {{(WIDTH-1){1'b0}}, bit_in};
          cnt_nx   = CW'(1);
        end
        S_DATA: begin
          if (last) begin
`ifdef BIT_DESER_PARITY_EN
            state_nx = S_PAR;
            sh_nx    = merged;
            cnt_nx   = '0;
`else
            push     = 1'b1;
            state_nx = S_IDLE;
            sh_nx    = '0;
            cnt_nx   = '0;
`endif
          end else begin
            sh_nx  = merged;
            cnt_nx = cnt + CW'(1);
          end
        end
`ifdef BIT_DESER_PARITY_EN
        S_PAR: begin
          // Word is pushed whatever the parity outcome.
          push      = 1'b1;
          push_data = sh;
          perr_nx   = (^sh) ^ bit_in;
          state_nx  = S_IDLE;
          sh_nx     = '0;
          cnt_nx    = '0;
        end
`endif
        default: begin
          state_nx = S_IDLE;
          sh_nx    = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sh    <= sh_nx;
      cnt   <= cnt_nx;
    end
  end

`ifdef BIT_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= perr_nx;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign pop      = word_vld && word_rdy;
  assign word_vld = !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push && full && !pop) begin
      ovf <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (word_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_bit_deser.sv
// Self-checking bench for bit_deser (WIDTH=8, DEPTH=4). Honors
// BIT_DESER_PARITY_EN the same way as the design.
module tb_bit_deser;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
`ifdef BIT_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  bit_in = 1'b0;
  logic                  bit_vld = 1'b0;
  logic                  sync = 1'b0;
  logic                  word_rdy = 1'b0;
  logic [W-1:0]          word_out;
  logic                  word_vld;
  logic [$clog2(D):0]    count;
  logic                  ovf;
  logic                  par_err;

  int total = 0;
  int bad   = 0;

  bit_deser #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .sync     (sync),
    .word_out (word_out),
    .word_vld (word_vld),
    .word_rdy (word_rdy),
    .count    (count),
    .ovf      (ovf),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: list of queued words plus the bits collected so far.
  logic [W-1:0] q[$];
  int unsigned  acc;
  int           nbits;
  bit           await_par;
  bit           m_ovf;
  bit           m_perr;

  function automatic void cmp(input string name, input int unsigned act,
                              input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model();
    bit           full_b;
    bit           popv;
    bit           pushv;
    logic [W-1:0] pword;
    pushv = 1'b0;
    pword = '0;
    if (rst) begin
      q.delete();
      acc = 0; nbits = 0; await_par = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    m_perr = 0;
    full_b = (q.size() == D);
    popv   = (q.size() > 0) && word_rdy;
    if (popv) void'(q.pop_front());
    if (sync) begin
      acc = 0; nbits = 0; await_par = 0;
      if (bit_vld) begin acc = int'(bit_in); nbits = 1; end
    end else if (bit_vld) begin
      if (await_par) begin
        pushv  = 1'b1;
        pword  = acc[W-1:0];
        m_perr = (^acc[W-1:0]) ^ bit_in;
        acc = 0; nbits = 0; await_par = 0;
      end else begin
        acc = acc | (int'(bit_in) << nbits);
        nbits++;
        if (nbits == W) begin
          if (PAR) await_par = 1;
          else begin
            pushv = 1'b1; pword = acc[W-1:0]; acc = 0; nbits = 0;
          end
        end
      end
    end
    if (pushv) begin
      if (full_b && !popv) m_ovf = 1;
      else q.push_back(pword);
    end
  endfunction

  task automatic check();
    cmp("word_vld", word_vld, (q.size() > 0) ? 1 : 0);
    cmp("count", count, q.size());
    cmp("ovf", ovf, m_ovf);
    cmp("par_err", par_err, m_perr);
    if (q.size() > 0) cmp("word_out", word_out, q[0]);
  endtask

  task automatic step(input logic b, input logic v, input logic s,
                      input logic r, input logic rd);
    bit_in = b; bit_vld = v; sync = s; rst = r; word_rdy = rd;
    @(posedge clk);
    model();
    #1 check();
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rd);
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n,
                           input logic rd, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) step(1'b1, 1'b0, 1'b0, 1'b0, rd);
      step(w[i], 1'b1, 1'b0, 1'b0, rd);
    end
  endtask

  task automatic send_par(input logic [W-1:0] w, input logic rd);
    if (PAR) step(^w, 1'b1, 1'b0, 1'b0, rd);
  endtask

  // Full word (plus even parity when enabled); rd_last applies to the
  // completing bit only.
  task automatic send(input logic [W-1:0] w, input logic rd,
                      input logic rd_last);
    if (PAR) begin
      send_bits(w, W, rd, 1'b0);
      send_par(w, rd_last);
    end else begin
      send_bits(w, W - 1, rd, 1'b0);
      step(w[W-1], 1'b1, 1'b0, 1'b0, rd_last);
    end
  endtask

  logic [W-1:0] exp_words [5];

  initial begin
    exp_words[0] = 8'hA1; exp_words[1] = 8'hB2; exp_words[2] = 8'hC3;
    exp_words[3] = 8'hD4; exp_words[4] = 8'hE5;

    // Reset state
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("rst_count", count, 0);
    cmp("rst_vld", word_vld, 0);
    cmp("rst_word", word_out, 0);
    cmp("rst_ovf", ovf, 0);
    cmp("rst_perr", par_err, 0);

    // Bits 1,0,1,1,0,0,0,1 -> 8'h8D, one cycle latency, one cycle valid
    send(8'h8D, 1'b1, 1'b1);
    cmp("lsb_vld", word_vld, 1);
    cmp("lsb_word", word_out, 8'h8D);
    idle(1, 1'b1);
    cmp("lsb_popped", word_vld, 0);

    // 3 bits, sync with bit 1, 7 zeros -> 8'h01 only
    send_bits(8'h07, 3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(8'h00, 7, 1'b1, 1'b0);
    send_par(8'h01, 1'b1);
    cmp("sync_count", count, 1);
    cmp("sync_word", word_out, 8'h01);
    idle(2, 1'b1);

    // Overflow: five words into four entries, then drain in order
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(exp_words[i], 1'b0, 1'b0);
    cmp("ovf_count", count, 4);
    cmp("ovf_flag", ovf, 1);
    for (int i = 0; i < 4; i++) begin
      cmp("drain_order", word_out, exp_words[i]);
      idle(1, 1'b1);
    end
    cmp("drain_empty", word_vld, 0);
    cmp("ovf_sticky", ovf, 1);

    // Push and pop together while full
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(exp_words[i], 1'b0, 1'b0);
    send(8'h77, 1'b0, 1'b1);
    cmp("fullpp_count", count, 4);
    cmp("fullpp_ovf", ovf, 0);
    cmp("fullpp_head", word_out, 8'hB2);
    idle(6, 1'b1);

    // Reset mid-word with words queued
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send_bits(8'h0F, 4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cmp("midrst_count", count, 0);
    cmp("midrst_vld", word_vld, 0);
    send(8'h5A, 1'b0, 1'b0);
    cmp("fresh_word", word_out, 8'h5A);
    cmp("fresh_count", count, 1);
    idle(1, 1'b1);

    // Sync colliding with the completing bit, and gapped bit_vld
    send_bits(8'hFF, 7, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cmp("collide_nopush", word_vld, 0);
    send_bits(8'h40, 7, 1'b0, 1'b1);
    send_par(8'h81, 1'b0);
    cmp("collide_word", word_out, 8'h81);
    send_bits(8'h3C, W, 1'b0, 1'b1);
    send_par(8'h3C, 1'b0);
    idle(4, 1'b1);
    cmp("gap_drained", count, 0);

`ifdef BIT_DESER_PARITY_EN
    // 8'h03 with parity 1 -> error pulse; with parity 0 -> none
    send_bits(8'h03, W, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("par_bad_pulse", par_err, 1);
    cmp("par_bad_word", word_out, 8'h03);
    idle(1, 1'b0);
    cmp("par_pulse_end", par_err, 0);
    send_bits(8'h03, W, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("par_good", par_err, 0);
    cmp("par_count", count, 2);
    idle(3, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_deser.md
BIT_DESER -- requirements
Module: bit_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per word (2..32).
REQ-002 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of 2, >=2).
REQ-003 SHALL have the port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have the port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have the port bit_in  input  1  serial data bit from the upstream XOR/mask stage.
REQ-006 SHALL have the port bit_vld  input  1  bit_in is valid this cycle.
REQ-007 SHALL have the port sync  input  1  word-alignment restart.
REQ-008 SHALL have the port word_out  output  WIDTH  FIFO head word.
REQ-009 SHALL have the port word_vld  output  1  FIFO not empty.
REQ-010 SHALL have the port word_rdy  input  1  consumer accepts the head word.
REQ-011 SHALL have the port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-012 SHALL have the port ovf  output  1  sticky overflow flag.
REQ-013 SHALL have the port par_err  output  1  parity-error pulse.

Function
REQ-014 SHALL accept a bit only when bit_vld=1, with bits packed LSB first (first accepted bit goes to word bit 0).
REQ-015 SHALL use an FSM with states S_IDLE (no bits held), S_DATA (1..WIDTH-1 bits held) and S_PAR (awaiting parity bit).
REQ-016 SHALL, in S_IDLE, move to S_DATA on an accepted bit.
REQ-017 SHALL, in S_DATA, push the assembled word on the WIDTH-th accepted bit and return to S_IDLE (or move to S_PAR per REQ-029).
REQ-018 SHALL make a pushed word visible on word_out/word_vld in the cycle after its last bit is accepted (1-cycle latency into an empty FIFO).
REQ-019 SHALL pop the head on word_vld&&word_rdy; word_out SHALL be registered FIFO head and SHALL hold its value while word_vld=1 and word_rdy=0.
REQ-020 SHALL allow push and pop in the same cycle, including when full, with count unchanged.
REQ-021 SHALL, on a push when full without a pop, drop the word, leave the FIFO unchanged, and set ovf=1 until rst.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL, when sync=1, discard partial bits and enter S_IDLE; a bit accepted in the same cycle SHALL become bit 0 of the new word (moving to S_DATA).
REQ-024 SHALL leave FIFO contents unaffected by sync.
REQ-025 SHALL let sync take priority over word completion in the same cycle (no push).

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set FSM=S_IDLE, pointers=0, count=0, word_vld=0, word_out=0, ovf=0, par_err=0.
REQ-027 SHALL, on reset mid-word or with FIFO non-empty, discard all held bits and words.
REQ-028 SHALL give rst priority over all other inputs.

Configuration
REQ-029 SHALL, with BIT_DESER_PARITY_EN defined, go from S_DATA to S_PAR after the WIDTH-th bit, then push on the next accepted bit (the even-parity bit); the word SHALL be pushed regardless of parity result, and par_err SHALL pulse high 1 cycle, in the cycle after the parity bit, if XOR(data, parity) != 0.
REQ-030 SHALL, without BIT_DESER_PARITY_EN, make S_PAR unreachable, tie par_err to constant 0, and keep the port present.

Structure
REQ-031 SHALL place FSM state typedef (S_IDLE/S_DATA/S_PAR) and default WIDTH/DEPTH constants in shared package bit_pkg.
REQ-032 SHALL implement the FIFO as a sub-module sync_fifo (push/pop/full/empty/count), instantiated once.

Verification
REQ-033 SHALL verify: 8 bits 1,0,1,1,0,0,0,1 with word_rdy=1 -> word_out=8'h8D, word_vld=1 for one cycle, 1 cycle after last bit.
REQ-034 SHALL verify: 5 words with word_rdy=0, DEPTH=4 -> count=4, ovf=1, fifth word lost; then drain -> first four words in order.
REQ-035 SHALL verify: 3 bits, then sync with bit_in=1, then 7 bits 0 -> word_out=8'h01, no word from the partial bits.
REQ-036 SHALL verify: full FIFO with word_rdy=1 while a word completes -> count stays 4, ovf=0.
REQ-037 SHALL verify: rst asserted after 4 bits with 2 words queued -> count=0, word_vld=0; next 8 bits form a fresh word.
REQ-038 SHALL verify, with BIT_DESER_PARITY_EN: data 8'h03 with parity bit 1 -> word 8'h03 pushed, par_err=1 one cycle; parity bit 0 -> par_err=0.
